// File: rtl/depacketizer_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ packet requesters into one registered
// output slot feeding a depacketizer; empty packets (head valid bit clear) are consumed without loading.
module depacketizer_rr_arbiter #(
  parameter int WIDTH_PKT = 36,
  parameter int NUM_REQ   = 4,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int VALID_POS = WIDTH_PKT - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*WIDTH_PKT-1:0] data_in,
  input  logic [NUM_REQ-1:0]           valid_in,
  output logic [NUM_REQ-1:0]           ready_out,
  output logic [WIDTH_PKT-1:0]         data_out,
  output logic                         valid_out,
  output logic [SRC_W-1:0]             src_out,
  input  logic                         ready_in
);

  logic [SRC_W-1:0]     ptr;
  logic [SRC_W-1:0]     off;
  logic [SRC_W-1:0]     gnt;
  logic [SRC_W-1:0]     nxt_ptr;
  logic [SRC_W:0]       sum;
  logic                 gnt_vld;
  logic                 can_load;
  logic                 xfer;
  logic                 head_vld;
  logic [2*NUM_REQ-1:0] vv_sh;
  logic [NUM_REQ-1:0]   rot;
  logic [WIDTH_PKT-1:0] pkt [NUM_REQ];
  logic [WIDTH_PKT-1:0] sel_pkt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign pkt[i] = data_in[i*WIDTH_PKT +: WIDTH_PKT];
  end

  // Rotate requests so the pointer position lands at bit 0; the first set bit is the winner offset.
  assign vv_sh = {valid_in, valid_in} >> ptr;
  assign rot   = vv_sh[NUM_REQ-1:0];

  always_comb begin
    off     = '0;
    gnt_vld = |rot;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SRC_W'(k);
    end
  end

  assign sum     = {1'b0, off} + {1'b0, ptr};
  assign gnt     = (sum >= (SRC_W+1)'(NUM_REQ)) ? SRC_W'(sum - (SRC_W+1)'(NUM_REQ))
                                                : sum[SRC_W-1:0];
  assign nxt_ptr = (gnt == SRC_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
  assign sel_pkt  = pkt[gnt];
  assign head_vld = sel_pkt[VALID_POS];

  assign can_load = ~valid_out | ready_in;
  assign xfer     = gnt_vld & can_load & rst_n;

  always_comb begin
    ready_out = '0;
    if (xfer) ready_out[gnt] = 1'b1;
  end

  // Output slot stage: loads on a non-empty transfer, otherwise drains when downstream accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      src_out   <= '0;
    end else begin
      if (xfer) ptr <= nxt_ptr;
      if (xfer && head_vld) begin
        valid_out <= 1'b1;
        data_out  <= sel_pkt;
        src_out   <= gnt;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
